banner_overlay_compositor: RTL and testbench

- Parametrised successor to the per-state title, pause and game-over banner overlays.
- Composites one ROM-backed banner sprite over an upstream scene pixel stream at a configurable window.
- Pipelines the ROM address, ROM data and pixel context, so the sprite colour is always aligned with its own (x, y).
- Adds a frame-synchronous show/blink state machine, so renderers can request steady or blinking banners (e.g. "PAUSED", "GAME OVER").

---
 rtl/banner_overlay_compositor.sv | 248 ++++++++++++++++++++++++
 tb/tb_banner_overlay_compositor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/banner_overlay_compositor.sv
// banner_overlay_compositor: overlays a ROM-backed banner sprite on a scene pixel stream, with a frame-synchronous show/blink FSM.
// Latency: pix_valid -> color_valid is ROM_LATENCY+2 cycles, fixed; every cycle advances the pipeline, valid or not.
// Backpressure: none; the stream is free-running. Optional macro OVERLAY_BORDER_EN adds a 1-pixel border in BORDER_COLOR.
module banner_overlay_compositor #(
  parameter int SPRITE_W = 122,
  parameter int SPRITE_H = 26,
  parameter int SPRITE_L = 18,
  parameter int SPRITE_T = 46,
  parameter int ADDR_W = 12,
  parameter int COLOR_W = 3,
  parameter logic [COLOR_W-1:0] TRANSPARENT = 3'b101,
  parameter int ROM_LATENCY = 1,
  parameter int BLINK_ON_FRAMES = 30,
  parameter int BLINK_OFF_FRAMES = 15
`ifdef OVERLAY_BORDER_EN
  , parameter logic [COLOR_W-1:0] BORDER_COLOR = 3'b000
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               pix_valid,
  input  logic [7:0]         x,
  input  logic [7:0]         y,
  input  logic [COLOR_W-1:0] scene_color,
  input  logic               overlay_en,
  input  logic               blink_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_q,
  output logic [COLOR_W-1:0] color,
  output logic               color_valid,
  output logic               visible
);

  // Context travels 1 (address register) + ROM_LATENCY stages so it lines up with rom_q.
  localparam int DLY = 1 + ROM_LATENCY;
  localparam int AW8 = ADDR_W + 8;
  localparam int CNT_MAX = (BLINK_ON_FRAMES > BLINK_OFF_FRAMES) ? BLINK_ON_FRAMES : BLINK_OFF_FRAMES;
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Window limits at 9 bits so that L+W = 256 does not wrap to 0.
  localparam logic [8:0] WIN_L = 9'(SPRITE_L);
  localparam logic [8:0] WIN_R = 9'(SPRITE_L + SPRITE_W);
  localparam logic [8:0] WIN_T = 9'(SPRITE_T);
  localparam logic [8:0] WIN_B = 9'(SPRITE_T + SPRITE_H);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(BLINK_ON_FRAMES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(BLINK_OFF_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  typedef struct packed {
    logic               vld;
    logic               in_win;
    logic               vis;
`ifdef OVERLAY_BORDER_EN
    logic               border;
`endif
    logic [COLOR_W-1:0] scene;
  } ctx_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_inc_d;
  logic               visible_q;

  logic [8:0]         x9;
  logic [8:0]         y9;
  logic               in_win_d;
  logic [AW8-1:0]     row_off;
  logic [AW8-1:0]     col_off;
  logic [ADDR_W-1:0]  addr_d;
  logic [ADDR_W-1:0]  rom_addr_q;

  ctx_t               ctx_d;
  ctx_t [DLY-1:0]     ctx_q;
  ctx_t               ctx_o;

  logic [COLOR_W-1:0] color_d;
  logic [COLOR_W-1:0] color_q;
  logic               color_valid_q;

  // ---------------------------------------------------------------------------
  // Stage 0: window test and row-major sprite address, purely combinational.
  // ---------------------------------------------------------------------------
  assign x9 = {1'b0, x};
  assign y9 = {1'b0, y};

  assign in_win_d = (x9 >= WIN_L) && (x9 < WIN_R) && (y9 >= WIN_T) && (y9 < WIN_B);

  // Offsets are only meaningful inside the window; outside, the address is forced to 0.
  assign row_off = AW8'(y) - AW8'(SPRITE_T);
  assign col_off = AW8'(x) - AW8'(SPRITE_L);
  assign addr_d  = in_win_d ? ADDR_W'(row_off * AW8'(SPRITE_W) + col_off) : '0;

`ifdef OVERLAY_BORDER_EN
  // Border ring one pixel outside the sprite; signed compares drop edges beyond 0..255.
  localparam logic signed [10:0] BL_S = 11'(SPRITE_L - 1);
  localparam logic signed [10:0] BR_S = 11'(SPRITE_L + SPRITE_W);
  localparam logic signed [10:0] BT_S = 11'(SPRITE_T - 1);
  localparam logic signed [10:0] BB_S = 11'(SPRITE_T + SPRITE_H);

  logic signed [10:0] xs;
  logic signed [10:0] ys;
  logic               border_d;

  assign xs = signed'({3'b000, x});
  assign ys = signed'({3'b000, y});
  assign border_d = (((ys == BT_S) || (ys == BB_S)) && (xs >= BL_S) && (xs <= BR_S)) ||
                    (((xs == BL_S) || (xs == BR_S)) && (ys >= BT_S) && (ys <= BB_S));
`endif

  // Pixel context sampled together with the FSM output, so a state change never splits a pixel.
  always_comb begin
    ctx_d        = '0;
    ctx_d.vld    = pix_valid;
    ctx_d.in_win = in_win_d;
    ctx_d.vis    = visible_q;
`ifdef OVERLAY_BORDER_EN
    ctx_d.border = border_d;
`endif
    ctx_d.scene  = scene_color;
  end

  // ---------------------------------------------------------------------------
  // Stage 1 and ROM wait: registered ROM address plus the context delay line.
  // ---------------------------------------------------------------------------

  // Register the sprite ROM address.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr_q <= '0;
    end else begin
      rom_addr_q <= addr_d;
    end
  end

  // Shift pixel context alongside the ROM access; reset drops in-flight pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctx_q <= '0;
    end else begin
      ctx_q[0] <= ctx_d;
      for (int i = 1; i < DLY; i++) begin
        ctx_q[i] <= ctx_q[i-1];
      end
    end
  end

  assign ctx_o = ctx_q[DLY-1];

  // ---------------------------------------------------------------------------
  // Output stage: pick sprite, border or scene colour for the aligned pixel.
  // ---------------------------------------------------------------------------

  // Select the composited colour; transparent ROM texels let the scene through.
  always_comb begin
    color_d = ctx_o.scene;
    if (ctx_o.in_win && ctx_o.vis && (rom_q != TRANSPARENT)) begin
      color_d = rom_q;
    end
`ifdef OVERLAY_BORDER_EN
    if (ctx_o.border && ctx_o.vis) begin
      color_d = BORDER_COLOR;
    end
`endif
  end

  // Register the final colour and its valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      color_q       <= '0;
      color_valid_q <= 1'b0;
    end else begin
      color_q       <= color_d;
      color_valid_q <= ctx_o.vld;
    end
  end

  // ---------------------------------------------------------------------------
  // Show/blink FSM: moves only on frame_tick so a banner never changes mid-frame.
  // ---------------------------------------------------------------------------

  // Saturating increment keeps the frame counter from wrapping.
  assign cnt_inc_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // State, frame counter and registered visible flag, updated on frame ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      visible_q <= 1'b0;
    end else if (frame_tick) begin
      unique case (state_q)
        ST_OFF: begin
          cnt_q <= '0;
          if (overlay_en) begin
            state_q   <= ST_ON;
            visible_q <= 1'b1;
          end
        end
        ST_ON: begin
          if (!overlay_en) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            visible_q <= 1'b0;
          end else if (blink_en && (cnt_q == ON_LAST)) begin
            state_q   <= ST_BLANK;
            cnt_q     <= '0;
            visible_q <= 1'b0;
          end else if (blink_en) begin
            cnt_q <= cnt_inc_d;
          end else begin
            cnt_q <= '0;
          end
        end
        ST_BLANK: begin
          if (!overlay_en) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            visible_q <= 1'b0;
          end else if (!blink_en || (cnt_q == OFF_LAST)) begin
            state_q   <= ST_ON;
            cnt_q     <= '0;
            visible_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        default: begin
          state_q   <= ST_OFF;
          cnt_q     <= '0;
          visible_q <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr    = rom_addr_q;
  assign color       = color_q;
  assign color_valid = color_valid_q;
  assign visible     = visible_q;

endmodule

// File: tb/tb_banner_overlay_compositor.sv
// Testbench for banner_overlay_compositor: two instances (ROM latency 1 and 3) share one pixel stream.
// Expected colours come from a pixel-level reference model scheduled into per-cycle expectation slots.
// Directed steps cover reset, addressing, transparency, blink pattern and reset-on-tick, then random traffic.
module tb_banner_overlay_compositor;

  localparam int W   = 122;
  localparam int H   = 26;
  localparam int L   = 18;
  localparam int T   = 46;
  localparam int TR  = 5;
  localparam int ON_F  = 2;
  localparam int OFF_F = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  x = 8'd0;
  logic [7:0]  y = 8'd0;
  logic [2:0]  scene_color = 3'd0;
  logic        overlay_en = 1'b0;
  logic        blink_en = 1'b0;

  logic [11:0] rom_addr1, rom_addr3;
  logic [2:0]  rom_q1, rom_q3, color1, color3;
  logic        cv1, cv3, vis1, vis3;
  logic [2:0]  r3a, r3b;

  logic [2:0]  rom_mem [4096];

  always #5 clk = ~clk;

  banner_overlay_compositor #(
    .ROM_LATENCY(1), .BLINK_ON_FRAMES(ON_F), .BLINK_OFF_FRAMES(OFF_F)
  ) dut1 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pix_valid(pix_valid),
    .x(x), .y(y), .scene_color(scene_color), .overlay_en(overlay_en), .blink_en(blink_en),
    .rom_addr(rom_addr1), .rom_q(rom_q1), .color(color1), .color_valid(cv1), .visible(vis1)
  );

  banner_overlay_compositor #(
    .ROM_LATENCY(3), .BLINK_ON_FRAMES(ON_F), .BLINK_OFF_FRAMES(OFF_F)
  ) dut3 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pix_valid(pix_valid),
    .x(x), .y(y), .scene_color(scene_color), .overlay_en(overlay_en), .blink_en(blink_en),
    .rom_addr(rom_addr3), .rom_q(rom_q3), .color(color3), .color_valid(cv3), .visible(vis3)
  );

  // Behavioural synchronous ROMs with 1 and 3 cycles of read latency.
  always @(posedge clk) begin
    rom_q1 <= rom_mem[rom_addr1];
    r3a    <= rom_mem[rom_addr3];
    r3b    <= r3a;
    rom_q3 <= r3b;
  end

  // Reference model state.
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          m_state = 0;   // 0 hidden/off, 1 shown, 2 blink-hidden
  int          m_cnt = 0;
  bit          m_vis = 1'b0;
  int          e_addr = 0;
  bit          ev1 [16];
  bit          ev3 [16];
  logic [2:0]  ec1 [16];
  logic [2:0]  ec3 [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Evaluate the pixel and frame rules for the inputs about to be sampled.
  task automatic model_step();
    int xi = int'(x);
    int yi = int'(y);
    int addr;
    int rq;
    logic [2:0] ec;
    bit inw;
    if (reset) begin
      for (int k = 1; k <= 5; k++) begin
        ev1[(cyc + k) % 16] = 1'b0;
        ev3[(cyc + k) % 16] = 1'b0;
      end
      m_state = 0;
      m_cnt   = 0;
      e_addr  = 0;
    end else begin
      inw  = (xi >= L) && (xi < L + W) && (yi >= T) && (yi < T + H);
      addr = inw ? (yi - T) * W + (xi - L) : 0;
      rq   = int'(rom_mem[addr]);
      ec   = (inw && m_vis && rq != TR) ? 3'(rq) : scene_color;
`ifdef OVERLAY_BORDER_EN
      if (m_vis && ((((yi == T - 1) || (yi == T + H)) && xi >= L - 1 && xi <= L + W) ||
                    (((xi == L - 1) || (xi == L + W)) && yi >= T - 1 && yi <= T + H)))
        ec = 3'b000;
`endif
      ev1[(cyc + 3) % 16] = pix_valid;
      ec1[(cyc + 3) % 16] = ec;
      ev3[(cyc + 5) % 16] = pix_valid;
      ec3[(cyc + 5) % 16] = ec;
      e_addr = addr;
      if (frame_tick) begin
        if (m_state == 0) begin
          if (overlay_en) begin m_state = 1; m_cnt = 0; end
        end else if (!overlay_en) begin
          m_state = 0; m_cnt = 0;
        end else if (m_state == 1) begin
          if (!blink_en) m_cnt = 0;
          else if (m_cnt == ON_F - 1) begin m_state = 2; m_cnt = 0; end
          else m_cnt++;
        end else begin
          if (!blink_en || m_cnt == OFF_F - 1) begin m_state = 1; m_cnt = 0; end
          else m_cnt++;
        end
      end
    end
    m_vis = (m_state == 1);
  endtask

  // One clock: update the model, let the edge happen, then check all outputs.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("visible1", 32'(vis1), 32'(m_vis));
    chk("visible3", 32'(vis3), 32'(m_vis));
    chk("rom_addr1", 32'(rom_addr1), 32'(e_addr));
    chk("rom_addr3", 32'(rom_addr3), 32'(e_addr));
    chk("color_valid1", 32'(cv1), 32'(ev1[cyc % 16]));
    if (ev1[cyc % 16]) chk("color1", 32'(color1), 32'(ec1[cyc % 16]));
    chk("color_valid3", 32'(cv3), 32'(ev3[cyc % 16]));
    if (ev3[cyc % 16]) chk("color3", 32'(color3), 32'(ec3[cyc % 16]));
  endtask

  task automatic pixel(input int px, input int py, input int sc);
    pix_valid   = 1'b1;
    x           = 8'(px);
    y           = 8'(py);
    scene_color = 3'(sc);
    step();
    pix_valid   = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 3'($urandom_range(0, 7));
    rom_mem[0]    = 3'b011;
    rom_mem[5]    = 3'b101;
    rom_mem[3171] = 3'b010;

    // Reset held for two cycles.
    reset = 1'b1;
    idle(2);
    chk("rst_color", 32'(color1), 32'd0);
    chk("rst_color_valid", 32'(cv1), 32'd0);
    chk("rst_visible", 32'(vis1), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr1), 32'd0);
    reset = 1'b0;
    idle(1);

    // Show the banner, then place the first sprite pixel.
    overlay_en = 1'b1;
    tick();
    chk("visible_after_tick", 32'(vis1), 32'd1);
    pixel(18, 46, 0);
    idle(2);
    chk("first_pixel_color", 32'(color1), 32'b011);
    chk("first_pixel_valid", 32'(cv1), 32'd1);

    // Address corners and out-of-window pixels.
    pixel(139, 71, 1);
    chk("addr_139_71", 32'(rom_addr1), 32'd3171);
    pixel(17, 46, 4);
    chk("addr_17_46", 32'(rom_addr1), 32'd0);
    pixel(140, 46, 7);
    chk("addr_140_46", 32'(rom_addr1), 32'd0);
    idle(1);
    chk("left_outside_scene", 32'(color1), 32'd4);

    // Transparent texel shows the scene.
    pixel(23, 46, 6);
    idle(2);
    chk("transparent", 32'(color1), 32'b110);

    // Blink pattern with 2 on / 1 off frames.
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    overlay_en = 1'b1;
    blink_en   = 1'b1;
    tick(); chk("blink_t1", 32'(vis1), 32'd1); idle(3);
    tick(); chk("blink_t2", 32'(vis1), 32'd1); idle(3);
    tick(); chk("blink_t3", 32'(vis1), 32'd0); idle(3);
    tick(); chk("blink_t4", 32'(vis1), 32'd1); idle(1);

    // Dropping the request mid-frame only takes effect on the next tick.
    overlay_en = 1'b0;
    idle(4);
    chk("drop_hold", 32'(vis1), 32'd1);
    tick();
    chk("drop_off", 32'(vis1), 32'd0);

    // Reset coinciding with a tick wins.
    overlay_en = 1'b1;
    blink_en   = 1'b0;
    tick();
    pixel(30, 50, 2);
    reset      = 1'b1;
    frame_tick = 1'b1;
    pix_valid  = 1'b1;
    step();
    chk("rst_tick_visible", 32'(vis1), 32'd0);
    chk("rst_tick_valid", 32'(cv1), 32'd0);
    reset      = 1'b0;
    frame_tick = 1'b0;
    pix_valid  = 1'b0;
    idle(6);
    chk("rst_flush_valid3", 32'(cv3), 32'd0);

    // Ten back-to-back pixels through both latencies.
    tick();
    for (int i = 0; i < 10; i++) pixel(14 + i, 50, i % 8);
    idle(6);

    // Randomised traffic with periodic frame ticks and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      frame_tick = (i % 23 == 0);
      if (frame_tick || $urandom_range(0, 15) == 0) begin
        overlay_en = ($urandom_range(0, 4) != 0);
        blink_en   = 1'($urandom_range(0, 1));
      end
      reset     = ($urandom_range(0, 249) == 0);
      pix_valid = ($urandom_range(0, 3) != 0);
      x = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(10, 150)) : 8'($urandom_range(0, 255));
      y = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(40, 76))  : 8'($urandom_range(0, 255));
      scene_color = 3'($urandom_range(0, 7));
      step();
    end
    reset      = 1'b0;
    frame_tick = 1'b0;
    pix_valid  = 1'b0;
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
